// File: rtl/cordic_pkg.sv
// Shared types and constants for the e^x CORDIC sequencing controller.
package cordic_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam int unsigned X_W = 32;  // 16.16 argument
    localparam int unsigned Y_W = 64;  // 32.32 result

    // ln(2^32) in 16.16: any larger magnitude overflows or underflows the 32.32 result
    localparam logic [X_W-1:0] SAT_THRESH = 32'h0016_2E43;
    localparam logic [Y_W-1:0] Y_ONES     = {Y_W{1'b1}};
    localparam logic [Y_W-1:0] Y_ZERO     = {Y_W{1'b0}};

endpackage

// File: rtl/cordic_range_chk.sv
// Splits a signed 16.16 argument into sign and magnitude and flags results
// that saturate without needing a core.
module cordic_range_chk
    import cordic_pkg::*;
(
    input  logic [X_W-1:0] x,
    output logic           sign,
    output logic [X_W-1:0] mag,
    output logic           sat
);

    assign sign = x[X_W-1];
    // 0x8000_0000 negates to itself, which still lands above the threshold
    assign mag  = sign ? (~x + 32'd1) : x;
    assign sat  = (mag >= SAT_THRESH);

endmodule

// File: rtl/cordic_ctrl.sv
// Request/response sequencer for a pair of e^x cores (positive / negative argument).
// Optional core-response watchdog enabled by defining CORDIC_CTRL_TIMEOUT_EN.
//
// state | meaning
// IDLE  | accept a request, range-check it
// LOAD  | one-cycle start pulse to the selected core
// WAIT  | wait for the selected core's done pulse
// HOLD  | present result until downstream accepts
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
)
(
    input  logic           clk,
    input  logic           rst,
    input  logic [X_W-1:0] in_x,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [Y_W-1:0] out_y,
    output logic           out_sat,
    output logic           out_err,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] core_x,
    output logic           core_en_p,
    output logic           core_en_n,
    input  logic [Y_W-1:0] core_y_p,
    input  logic [Y_W-1:0] core_y_n,
    input  logic           core_valid_p,
    input  logic           core_valid_n,
    output logic           core_rst
);

    state_t         state;
    logic           sign_r;
    logic           rc_sign;
    logic [X_W-1:0] rc_mag;
    logic           rc_sat;
    logic           core_done;

    cordic_range_chk u_range_chk (
        .x    (in_x),
        .sign (rc_sign),
        .mag  (rc_mag),
        .sat  (rc_sat)
    );

    // The unselected core's done pulse never reaches the FSM
    assign core_done = sign_r ? core_valid_n : core_valid_p;

`ifdef CORDIC_CTRL_TIMEOUT_EN
    logic        err_r;
    logic        to_pulse;
    logic [31:0] to_cnt;

    assign out_err  = err_r;
    assign core_rst = rst | to_pulse;
`else
    assign out_err  = 1'b0;
    assign core_rst = rst;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_y     <= Y_ZERO;
            out_sat   <= 1'b0;
            core_en_p <= 1'b0;
            core_en_n <= 1'b0;
            core_x    <= '0;
            sign_r    <= 1'b0;
`ifdef CORDIC_CTRL_TIMEOUT_EN
            err_r     <= 1'b0;
            to_pulse  <= 1'b0;
            to_cnt    <= '0;
`endif
        end else begin
            core_en_p <= 1'b0;
            core_en_n <= 1'b0;
`ifdef CORDIC_CTRL_TIMEOUT_EN
            to_pulse  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        sign_r   <= rc_sign;
                        if (rc_sat) begin
                            out_y     <= rc_sign ? Y_ZERO : Y_ONES;
                            out_sat   <= 1'b1;
                            out_valid <= 1'b1;
`ifdef CORDIC_CTRL_TIMEOUT_EN
                            err_r     <= 1'b0;
`endif
                            state     <= S_HOLD;
                        end else begin
                            core_x    <= rc_mag;
                            core_en_p <= ~rc_sign;
                            core_en_n <= rc_sign;
                            state     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
`ifdef CORDIC_CTRL_TIMEOUT_EN
                    to_cnt <= TIMEOUT_CYC - 32'd1;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        out_y     <= sign_r ? core_y_n : core_y_p;
                        out_sat   <= 1'b0;
                        out_valid <= 1'b1;
`ifdef CORDIC_CTRL_TIMEOUT_EN
                        err_r     <= 1'b0;
`endif
                        state     <= S_HOLD;
                    end
`ifdef CORDIC_CTRL_TIMEOUT_EN
                    else if (to_cnt == 32'd0) begin
                        out_y     <= Y_ZERO;
                        out_sat   <= 1'b0;
                        err_r     <= 1'b1;
                        to_pulse  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        to_cnt <= to_cnt - 32'd1;
                    end
`endif
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_ctrl.sv
// Directed self-checking bench for cordic_ctrl; the watchdog scenario follows
// whichever build CORDIC_CTRL_TIMEOUT_EN selects.
module tb_cordic_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_x;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_y;
    logic        out_sat;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] core_x;
    logic        core_en_p;
    logic        core_en_n;
    logic [63:0] core_y_p;
    logic [63:0] core_y_n;
    logic        core_valid_p;
    logic        core_valid_n;
    logic        core_rst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cordic_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_x         (in_x),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_y        (out_y),
        .out_sat      (out_sat),
        .out_err      (out_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .core_x       (core_x),
        .core_en_p    (core_en_p),
        .core_en_n    (core_en_n),
        .core_y_p     (core_y_p),
        .core_y_n     (core_y_n),
        .core_valid_p (core_valid_p),
        .core_valid_n (core_valid_n),
        .core_rst     (core_rst)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs changed 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] x);
        in_x     = x;
        in_valid = 1'b1;
        check("xfer_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drain_out_valid", {63'd0, out_valid}, 64'd0);
        check("drain_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    logic [31:0] sat_x   [4] = '{32'h0017_0000, 32'h0016_2E43, 32'hFFE9_D1BD, 32'h8000_0000};
    logic [63:0] sat_y   [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0};
    logic [31:0] ok_x    [3] = '{32'h0016_2E42, 32'hFFE9_D1BE, 32'h0000_0000};
    logic [31:0] ok_mag  [3] = '{32'h0016_2E42, 32'h0016_2E42, 32'h0000_0000};
    logic        ok_neg  [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        int bad;
        int n_en;
        rst = 1'b1; in_x = '0; in_valid = 1'b0; out_ready = 1'b0;
        core_y_p = '0; core_y_n = '0; core_valid_p = 1'b0; core_valid_n = 1'b0;

        // Reset state
        step(); step();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_y", out_y, 64'd0);
        check("rst_out_sat", {63'd0, out_sat}, 64'd0);
        check("rst_out_err", {63'd0, out_err}, 64'd0);
        check("rst_core_en", {62'd0, core_en_p, core_en_n}, 64'd0);
        check("rst_core_x", {32'd0, core_x}, 64'd0);
        check("rst_core_rst", {63'd0, core_rst}, 64'd1);
        rst = 1'b0;
        step();
        check("post_rst_core_rst", {63'd0, core_rst}, 64'd0);

        // e^1 through the positive core, answer 33 cycles after start
        xfer(32'h0001_0000);
        check("p_core_x", {32'd0, core_x}, 64'h0001_0000);
        check("p_en", {62'd0, core_en_p, core_en_n}, 64'd2);
        check("p_in_ready", {63'd0, in_ready}, 64'd0);
        n_en = 0; bad = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (core_en_p || core_en_n) n_en++;
            if (core_x !== 32'h0001_0000 || out_valid !== 1'b0) bad++;
        end
        check("p_single_en", 64'(n_en), 64'd0);
        check("p_wait_stable", 64'(bad), 64'd0);
        core_y_p = 64'h0000_0002_B7E1_5163; core_valid_p = 1'b1;
        core_y_n = 64'hDEAD_BEEF_DEAD_BEEF; core_valid_n = 1'b1;
        step();
        core_valid_p = 1'b0; core_valid_n = 1'b0;
        check("p_out_valid", {63'd0, out_valid}, 64'd1);
        check("p_out_y", out_y, 64'h0000_0002_B7E1_5163);
        check("p_out_sat", {63'd0, out_sat}, 64'd0);
        check("p_out_err", {63'd0, out_err}, 64'd0);
        drain();

        // e^-1 through the negative core; a stray positive-core pulse is ignored
        xfer(32'hFFFF_0000);
        check("n_core_x", {32'd0, core_x}, 64'h0001_0000);
        check("n_en", {62'd0, core_en_p, core_en_n}, 64'd1);
        step();
        core_y_p = 64'h1111_2222_3333_4444; core_valid_p = 1'b1;
        step();
        core_valid_p = 1'b0;
        check("n_ignore_p", {63'd0, out_valid}, 64'd0);
        core_y_n = 64'h0000_0000_5E2D_58D8; core_valid_n = 1'b1;
        step();
        core_valid_n = 1'b0;
        check("n_out_valid", {63'd0, out_valid}, 64'd1);
        check("n_out_y", out_y, 64'h0000_0000_5E2D_58D8);
        drain();

        // Saturating arguments, including both threshold edges
        for (int k = 0; k < 4; k++) begin
            xfer(sat_x[k]);
            check($sformatf("sat%0d_out_valid", k), {63'd0, out_valid}, 64'd1);
            check($sformatf("sat%0d_out_sat", k), {63'd0, out_sat}, 64'd1);
            check($sformatf("sat%0d_out_y", k), out_y, sat_y[k]);
            check($sformatf("sat%0d_no_en", k), {62'd0, core_en_p, core_en_n}, 64'd0);
            drain();
        end

        // Just below threshold (both signs) and x=0 go through a core
        for (int k = 0; k < 3; k++) begin
            xfer(ok_x[k]);
            check($sformatf("ok%0d_core_x", k), {32'd0, core_x}, {32'd0, ok_mag[k]});
            check($sformatf("ok%0d_en", k), {62'd0, core_en_p, core_en_n},
                  ok_neg[k] ? 64'd1 : 64'd2);
            check($sformatf("ok%0d_no_valid", k), {63'd0, out_valid}, 64'd0);
            step();
            core_y_p = 64'h0000_0000_0000_1234 + 64'(k);
            core_y_n = 64'h0000_0000_0000_5678 + 64'(k);
            if (ok_neg[k]) core_valid_n = 1'b1; else core_valid_p = 1'b1;
            step();
            core_valid_p = 1'b0; core_valid_n = 1'b0;
            check($sformatf("ok%0d_out_y", k), out_y,
                  ok_neg[k] ? 64'h5678 + 64'(k) : 64'h1234 + 64'(k));
            check($sformatf("ok%0d_out_sat", k), {63'd0, out_sat}, 64'd0);
            drain();
        end

        // Backpressure in HOLD with a new request waiting upstream
        xfer(32'h8000_0000);
        in_x = 32'h0017_0000; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_y !== 64'd0 || out_valid !== 1'b1 || in_ready !== 1'b0 || out_sat !== 1'b1) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold_release_valid", {63'd0, out_valid}, 64'd0);
        check("hold_release_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        check("held_req_valid", {63'd0, out_valid}, 64'd1);
        check("held_req_y", out_y, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        // Core never answers
        xfer(32'h0001_0000);
`ifdef CORDIC_CTRL_TIMEOUT_EN
        begin
            int n;
            int rst_seen;
            bit found;
            n = 0; rst_seen = 0; found = 1'b0;
            for (int i = 1; i <= 300 && !found; i++) begin
                step();
                if (core_rst) rst_seen++;
                if (out_valid) begin found = 1'b1; n = i; end
            end
            check("to_latency", 64'(n), 64'(TO + 1));
            check("to_out_err", {63'd0, out_err}, 64'd1);
            check("to_out_y", out_y, 64'd0);
            check("to_core_rst_now", {63'd0, core_rst}, 64'd1);
            step();
            if (core_rst) rst_seen++;
            check("to_core_rst_once", 64'(rst_seen), 64'd1);
            drain();
        end
`else
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_err !== 1'b0 || core_rst !== 1'b0) bad++;
        end
        check("no_to_still_wait", 64'(bad), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif

        // Reset while waiting, then a late core answer
        xfer(32'h0001_0000);
        step(); step(); step();
        rst = 1'b1;
        step();
        check("abort_core_rst", {63'd0, core_rst}, 64'd1);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_core_x", {32'd0, core_x}, 64'd0);
        rst = 1'b0;
        core_y_p = 64'hABCD_0000_0000_0001; core_valid_p = 1'b1;
        step();
        core_valid_p = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_y !== 64'd0) bad++;
            step();
        end
        check("abort_no_output", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/cordic_ctrl.md
CORDIC_CTRL -- requirements
Module: cordic_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, 64, core-response watchdog limit in cycles; used only with CORDIC_CTRL_TIMEOUT_EN.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_x  in  32  signed 16.16 exponent argument.
REQ-005 in_valid / in_ready  in/out  1  request handshake; transfer when both high.
REQ-006 out_y  out  64  unsigned 32.32 result e^x.
REQ-007 out_sat  out  1  result clamped, no core used.
REQ-008 out_err  out  1  core timeout (tied 0 without macro).
REQ-009 out_valid / out_ready  out/in  1  result handshake.
REQ-010 core_x  out  32  unsigned 16.16 magnitude to both exp cores.
REQ-011 core_en_p / core_en_n  out  1  start pulse to positive / negative core.
REQ-012 core_y_p, core_y_n  in  64  core results; core_valid_p, core_valid_n  in  1  core done pulses.
REQ-013 core_rst  out  1  reset to both cores.

Function
REQ-014 States: IDLE, LOAD, WAIT, HOLD.
REQ-015 IDLE: in_ready=1; on transfer, latch sign(in_x) and magnitude (two's-complement negate if negative).
REQ-016 Magnitude >= 0x0016_2E43 (ln 2^32): positive -> out_y=0xFFFF_FFFF_FFFF_FFFF, negative -> out_y=0; out_sat=1; go HOLD; out_valid high the cycle after transfer; no core_en.
REQ-017 Otherwise go LOAD; core_x = magnitude, held stable from transfer until leaving WAIT.
REQ-018 LOAD: one-cycle pulse on core_en_p (sign=0) or core_en_n (sign=1), never both; go WAIT.
REQ-019 WAIT: on the selected core's valid, latch its y into out_y, out_sat=0, go HOLD; the unselected core's valid is ignored.
REQ-020 HOLD: out_valid=1; out_y/out_sat/out_err stable until out_ready; on out_ready go IDLE; in_ready=0 outside IDLE.
REQ-021 x=0 uses positive core (no special case).
REQ-022 in_valid while not IDLE is not accepted and not lost; the upstream source holds it.

Reset
REQ-023 rst: state IDLE, in_ready=1, out_valid=0, out_y=0, out_sat=0, out_err=0, core_en_*=0, core_x=0, core_rst=1 for that cycle.
REQ-024 rst mid-LOAD/WAIT/HOLD aborts the operation; any late core valid is ignored; no out_valid produced.

Configuration
REQ-025 CORDIC_CTRL_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYC without the selected core's valid -> out_y=0, out_err=1, core_rst pulsed one cycle, go HOLD.
REQ-026 CORDIC_CTRL_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; out_err constant 0; core_rst driven only by rst.

Structure
REQ-027 Shared package cordic_pkg: state encoding, 16.16/32.32 width constants, saturation threshold 0x0016_2E43, all-ones and zero result constants.
REQ-028 One sub-module: cordic_range_chk (sign split, magnitude, threshold compare); the FSM stays in cordic_ctrl.

Verification
REQ-029 in_x=0x0001_0000; core model returns 0x0000_0002_B7E1_5163 after 33 cycles -> core_x=0x0001_0000, single core_en_p pulse, out_y matches, out_sat=0.
REQ-030 in_x=0xFFFF_0000 -> core_x=0x0001_0000, core_en_n only; core_y_n=0x0000_0000_5E2D_58D8 passed to out_y.
REQ-031 in_x=0x0017_0000 -> out_y all ones, out_sat=1, out_valid one cycle after transfer, no core_en; in_x=0x8000_0000 -> out_y=0, out_sat=1.
REQ-032 out_ready held low 5 cycles in HOLD -> out_y stable, in_ready=0, new in_valid not accepted until after the out_ready transfer.
REQ-033 With macro, core never responds -> out_err=1, out_y=0 at cycle TIMEOUT_CYC, one core_rst pulse; without macro -> still WAIT at cycle 200.
REQ-034 rst asserted in WAIT, core valid one cycle later -> state IDLE, out_valid stays 0.
